// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD reader/writer pair:
// FSM encoding, RS/RW bus encodings and default 50 MHz timing.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_EHIGH,
        ST_HOLD,
        ST_RECOVER,
        ST_DONE
    } lcd_state_t;

    localparam logic LCD_RS_CMD   = 1'b0;
    localparam logic LCD_RS_DATA  = 1'b1;
    localparam logic LCD_RW_WRITE = 1'b0;
    localparam logic LCD_RW_READ  = 1'b1;

    localparam int unsigned LCD_T_AS_CYC  = 3;
    localparam int unsigned LCD_T_EH_CYC  = 25;
    localparam int unsigned LCD_T_AH_CYC  = 2;
    localparam int unsigned LCD_T_REC_CYC = 25;
    localparam int unsigned LCD_MAX_POLLS = 1024;

    // A zero-length phase is stretched to one cycle.
    function automatic int unsigned eff_cyc(input int unsigned n);
        return (n == 0) ? 1 : n;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter with a zero flag; times one bus phase at a time.
module lcd_phase_timer #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_reader.sv
// Read-side HD44780 controller: timed status/data-RAM reads with RW=1,
// optional busy-flag polling with a poll limit.
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int unsigned T_AS_CYC  = LCD_T_AS_CYC,
    parameter int unsigned T_EH_CYC  = LCD_T_EH_CYC,
    parameter int unsigned T_AH_CYC  = LCD_T_AH_CYC,
    parameter int unsigned T_REC_CYC = LCD_T_REC_CYC,
    parameter int unsigned MAX_POLLS = LCD_MAX_POLLS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       req_rs,
    input  logic       req_poll,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       busy_flag,
    output logic [6:0] addr_ctr,
    output logic       timeout,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    input  logic [7:0] LCD_Data_in
);

    localparam int unsigned AS   = eff_cyc(T_AS_CYC);
    localparam int unsigned EH   = eff_cyc(T_EH_CYC);
    localparam int unsigned AH   = eff_cyc(T_AH_CYC);
    localparam int unsigned REC  = eff_cyc(T_REC_CYC);
    localparam int unsigned MP   = eff_cyc(MAX_POLLS);
    localparam int unsigned MAXC = max2(max2(AS, EH), max2(AH, REC));
    localparam int unsigned CW   = $clog2(MAXC + 1);
    localparam int unsigned PW   = $clog2(MP + 1);

    // Timer is loaded with N-1 so that a phase lasts exactly N cycles.
    localparam logic [CW-1:0] AS_LD  = CW'(AS - 1);
    localparam logic [CW-1:0] EH_LD  = CW'(EH - 1);
    localparam logic [CW-1:0] AH_LD  = CW'(AH - 1);
    localparam logic [CW-1:0] REC_LD = CW'(REC - 1);
    localparam logic [PW-1:0] MP_CNT = PW'(MP);

    lcd_state_t    state, state_d;
    logic          e_q, e_d;
    logic          rw_q, rw_d;
    logic          rs_q, rs_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          timeout_q, timeout_d;
    logic          poll_q, poll_d;
    logic [PW-1:0] poll_cnt, poll_cnt_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          bf_q, bf_d;
    logic [6:0]    ac_q, ac_d;

    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_zero;

    lcd_phase_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d    = state;
        e_d        = e_q;
        rw_d       = rw_q;
        rs_d       = rs_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        timeout_d  = timeout_q;
        poll_d     = poll_q;
        poll_cnt_d = poll_cnt;
        rd_data_d  = rd_data_q;
        bf_d       = bf_q;
        ac_d       = ac_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;

        unique case (state)
            ST_IDLE: ;
            ST_SETUP: begin
                if (tmr_zero) begin
                    state_d  = ST_EHIGH;
                    e_d      = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = EH_LD;
                end
            end
            ST_EHIGH: begin
                if (tmr_zero) begin
                    state_d   = ST_HOLD;
                    e_d       = 1'b0;
                    rd_data_d = LCD_Data_in;
                    if (rs_q == LCD_RS_CMD) begin
                        bf_d = LCD_Data_in[7];
                        ac_d = LCD_Data_in[6:0];
                    end
                    tmr_load = 1'b1;
                    tmr_val  = AH_LD;
                end
            end
            ST_HOLD: begin
                if (tmr_zero) begin
                    state_d  = ST_RECOVER;
                    rw_d     = LCD_RW_WRITE;
                    rs_d     = LCD_RS_CMD;
                    tmr_load = 1'b1;
                    tmr_val  = REC_LD;
                end
            end
            ST_RECOVER: begin
                if (tmr_zero) begin
                    if (poll_q && bf_q && (poll_cnt != MP_CNT)) begin
                        state_d    = ST_SETUP;
                        poll_cnt_d = poll_cnt + 1'b1;
                        rw_d       = LCD_RW_READ;
                        rs_d       = LCD_RS_CMD;
                        tmr_load   = 1'b1;
                        tmr_val    = AS_LD;
                    end else begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        timeout_d = poll_q && bf_q;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // busy is already low during DONE, so a request there starts the next read.
        if (req && ((state == ST_IDLE) || (state == ST_DONE))) begin
            state_d    = ST_SETUP;
            rw_d       = LCD_RW_READ;
            rs_d       = req_rs;
            busy_d     = 1'b1;
            timeout_d  = 1'b0;
            poll_cnt_d = '0;
            poll_d     = req_poll && (req_rs == LCD_RS_CMD);
            tmr_load   = 1'b1;
            tmr_val    = AS_LD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            e_q       <= 1'b0;
            rw_q      <= LCD_RW_WRITE;
            rs_q      <= LCD_RS_CMD;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            poll_q    <= 1'b0;
            poll_cnt  <= '0;
            rd_data_q <= '0;
            bf_q      <= 1'b0;
            ac_q      <= '0;
        end else begin
            state     <= state_d;
            e_q       <= e_d;
            rw_q      <= rw_d;
            rs_q      <= rs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            poll_q    <= poll_d;
            poll_cnt  <= poll_cnt_d;
            rd_data_q <= rd_data_d;
            bf_q      <= bf_d;
            ac_q      <= ac_d;
        end
    end

    assign LCD_E     = e_q;
    assign LCD_RW    = rw_q;
    assign LCD_RS    = rs_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign rd_data   = rd_data_q;
    assign busy_flag = bf_q;
    assign addr_ctr  = ac_q;

endmodule

// File: tb/tb_lcd_reader.sv
// Directed bench for lcd_reader with a simple LCD read-response model.
module tb_lcd_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic       req_rs;
    logic       req_poll;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       busy_flag;
    logic [6:0] addr_ctr;
    logic       timeout;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] lcd_data;

    logic [7:0] resp [0:7];
    int         resp_idx;

    int errors = 0;
    int checks = 0;

    int pulses, ehigh, first_e, last_e, rw_fall, rs_bad, e_no_rw, done_k, busy_at_done;

    lcd_reader #(.MAX_POLLS(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_rs      (req_rs),
        .req_poll    (req_poll),
        .busy        (busy),
        .done        (done),
        .rd_data     (rd_data),
        .busy_flag   (busy_flag),
        .addr_ctr    (addr_ctr),
        .timeout     (timeout),
        .LCD_E       (LCD_E),
        .LCD_RS      (LCD_RS),
        .LCD_RW      (LCD_RW),
        .LCD_Data_in (lcd_data)
    );

    always #10 clk = ~clk;

    // LCD drives the bus only while E is high.
    assign lcd_data = LCD_E ? resp[resp_idx] : 8'h00;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start(input logic rs, input logic poll, input logic hold);
        @(negedge clk);
        req      = 1'b1;
        req_rs   = rs;
        req_poll = poll;
        resp_idx = 0;
        @(posedge clk);
        #1;
        if (!hold) req = 1'b0;
        check_val("accept", {busy, LCD_RW, LCD_RS, LCD_E, timeout, done},
                  {1'b1, 1'b1, rs, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic track(input logic exp_rs, input int ovl_at);
        logic prev_e, prev_rw;
        pulses = 0; ehigh = 0; first_e = -1; last_e = -1; rw_fall = -1;
        rs_bad = 0; e_no_rw = 0; done_k = -1; busy_at_done = -1;
        prev_e = 1'b0; prev_rw = 1'b1;
        for (int k = 1; k <= 400 && done_k < 0; k++) begin
            @(posedge clk);
            #1;
            if (LCD_E) begin
                ehigh++;
                if (first_e < 0) first_e = k;
                last_e = k;
            end
            if (LCD_E && !prev_e) pulses++;
            if (!LCD_E && prev_e && resp_idx < 7) resp_idx++;
            if (!LCD_RW && prev_rw && rw_fall < 0) rw_fall = k;
            if (LCD_E && !LCD_RW) e_no_rw++;
            if (LCD_RW ? (LCD_RS !== exp_rs) : (LCD_RS !== 1'b0)) rs_bad++;
            if (done) begin
                done_k = k;
                busy_at_done = int'(busy);
            end
            prev_e  = LCD_E;
            prev_rw = LCD_RW;
            if (k == ovl_at) req = 1'b1;
            if (k == ovl_at + 1) req = 1'b0;
        end
        check_val("done_seen", done_k >= 0, 1);
        check_val("busy_at_done", busy_at_done, 0);
        check_val("e_without_rw", e_no_rw, 0);
        check_val("rs_level", rs_bad, 0);
    endtask

    task automatic idle_watch(input string tag);
        int act;
        act = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (busy || done || LCD_E || LCD_RW) act++;
        end
        check_val(tag, act, 0);
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; req_rs = 1'b0; req_poll = 1'b0; resp_idx = 0;
        for (int i = 0; i < 8; i++) resp[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("reset_state",
                  {LCD_E, LCD_RW, LCD_RS, busy, done, rd_data, busy_flag, addr_ctr, timeout}, 0);

        // Status read returning 0x25
        resp[0] = 8'h25;
        start(1'b0, 1'b0, 1'b0);
        track(1'b0, -1);
        check_val("st_done_cyc", done_k, 55);
        check_val("st_pulses", pulses, 1);
        check_val("st_setup", first_e, 3);
        check_val("st_ehigh", ehigh, 25);
        check_val("st_last_e", last_e, 27);
        check_val("st_rw_fall", rw_fall, 30);
        check_val("st_result", {rd_data, busy_flag, addr_ctr, timeout}, {8'h25, 1'b0, 7'h25, 1'b0});

        // Data read returning 0x41: busy_flag/addr_ctr untouched
        resp[0] = 8'h41;
        start(1'b1, 1'b0, 1'b0);
        track(1'b1, -1);
        check_val("dr_done_cyc", done_k, 55);
        check_val("dr_timing", {first_e[7:0], ehigh[7:0], rw_fall[7:0]}, {8'd3, 8'd25, 8'd30});
        check_val("dr_hold", rw_fall - (last_e + 1), 2);
        check_val("dr_result", {rd_data, busy_flag, addr_ctr}, {8'h41, 1'b0, 7'h25});

        // Poll: three busy reads then ready
        resp[0] = 8'h80; resp[1] = 8'h80; resp[2] = 8'h80; resp[3] = 8'h07;
        start(1'b0, 1'b1, 1'b0);
        track(1'b0, -1);
        check_val("poll_done_cyc", done_k, 220);
        check_val("poll_pulses", pulses, 4);
        check_val("poll_ehigh", ehigh, 100);
        check_val("poll_result", {rd_data, busy_flag, addr_ctr, timeout}, {8'h07, 1'b0, 7'h07, 1'b0});

        // Poll timeout with MAX_POLLS=4
        for (int i = 0; i < 8; i++) resp[i] = 8'h80;
        start(1'b0, 1'b1, 1'b0);
        track(1'b0, -1);
        check_val("to_done_cyc", done_k, 275);
        check_val("to_pulses", pulses, 5);
        check_val("to_result", {rd_data, busy_flag, addr_ctr, timeout}, {8'h80, 1'b1, 7'h00, 1'b1});

        // Data read with req_poll=1 (ignored) and a stray req during EHIGH
        resp[0] = 8'hC1;
        start(1'b1, 1'b1, 1'b0);
        track(1'b1, 10);
        check_val("ovl_done_cyc", done_k, 55);
        check_val("ovl_pulses", pulses, 1);
        check_val("ovl_result", {rd_data, busy_flag, addr_ctr, timeout}, {8'hC1, 1'b1, 7'h00, 1'b0});
        idle_watch("ovl_no_second");

        // req held high: next read accepted the edge after done
        resp[0] = 8'h33; resp[1] = 8'h34;
        start(1'b0, 1'b0, 1'b1);
        track(1'b0, -1);
        check_val("hold1_done_cyc", done_k, 55);
        check_val("hold1_data", rd_data, 8'h33);
        @(posedge clk);
        #1;
        check_val("reaccept", {busy, LCD_RW, done}, 3'b110);
        req = 1'b0;
        track(1'b0, -1);
        check_val("hold2_done_cyc", done_k, 55);
        check_val("hold2_result", {rd_data, addr_ctr}, {8'h34, 7'h34});
        idle_watch("hold_no_third");

        // Asynchronous reset during EHIGH
        resp[0] = 8'h99;
        start(1'b1, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check_val("pre_reset_e", {LCD_E, LCD_RW, busy}, 3'b111);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("reset_abort", {LCD_E, LCD_RW, LCD_RS, busy, done, rd_data}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_watch("reset_no_done");

        resp[0] = 8'h25;
        start(1'b0, 1'b0, 1'b0);
        track(1'b0, -1);
        check_val("resume_done_cyc", done_k, 55);
        check_val("resume_result", {rd_data, busy_flag, addr_ctr}, {8'h25, 1'b0, 7'h25});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
